// File: rtl/axi4_stream_pas_ctl_if.sv
// rtl/axi4_stream_pas_ctl_if.sv - observed stream handshake and gate enable between controller and gate
interface axi4_stream_pas_ctl_if;
  logic str_vld;
  logic str_rdy;
  logic str_lst;
  logic ena;

  // controller side: watches the ungated handshake, drives the gate enable
  modport master (
    input  str_vld,
    input  str_rdy,
    input  str_lst,
    output ena
  );

  // stream/gate side: supplies the handshake, receives the enable
  modport slave (
    output str_vld,
    output str_rdy,
    output str_lst,
    input  ena
  );
endinterface

// File: rtl/axi4_stream_pas_ctl.sv
// rtl/axi4_stream_pas_ctl.sv - arm/trigger/length/stop sequencer for the stream pass-through gate
module axi4_stream_pas_ctl #(
  parameter int CW = 32
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   ctl_rst,
  input  logic                   ctl_str,
  input  logic                   ctl_stp,
  input  logic                   trg,
  input  logic [CW-1:0]          cfg_len,
  input  logic                   cfg_pkt,
  axi4_stream_pas_ctl_if.master  str,
  output logic                   sts_arm,
  output logic                   sts_run,
  output logic [CW-1:0]          sts_cnt,
  output logic                   evt_end
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic          pkt;
  logic          pkt_nxt;
  logic [CW-1:0] cnt_nxt;
  logic          evt_nxt;
  logic          ena_nxt;
  logic          arm_nxt;
  logic          run_nxt;

  logic          xfr;
  logic [CW:0]   cnt_p1;
  logic [CW-1:0] cnt_sat;
  logic          len_hit;

  // ena is only ever high in RUN/DRAIN, so xfr needs no state qualifier
  assign xfr     = str.ena & str.str_vld & str.str_rdy;
  assign cnt_p1  = {1'b0, sts_cnt} + {{CW{1'b0}}, 1'b1};
  assign cnt_sat = (&sts_cnt) ? sts_cnt : cnt_p1[CW-1:0];
  // compared at CW+1 bits so a saturated counter can never alias a length
  assign len_hit = (cfg_len != '0) && xfr && (cnt_p1 == {1'b0, cfg_len});

  // state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next state, beat count and packet-position tracking
  always_comb begin
    state_nxt = state;
    cnt_nxt   = sts_cnt;
    pkt_nxt   = pkt;
    evt_nxt   = 1'b0;

    if (xfr) begin
      pkt_nxt = ~str.str_lst;
      cnt_nxt = cnt_sat;
    end

    if (ctl_rst) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      pkt_nxt   = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ctl_str) begin
            state_nxt = ARMED;
            cnt_nxt   = '0;
            pkt_nxt   = 1'b0;
          end
        end
        ARMED: begin
          if (ctl_stp) begin
            state_nxt = IDLE;
          end else if (ctl_str) begin
            pkt_nxt = 1'b0;
          end else if (trg) begin
            state_nxt = RUN;
          end
        end
        RUN: begin
          // stop and length-final beat together are one termination
          if (ctl_stp || len_hit) begin
            if (cfg_pkt && pkt_nxt) begin
              state_nxt = DRAIN;
            end else begin
              state_nxt = IDLE;
              evt_nxt   = 1'b1;
            end
          end
        end
        DRAIN: begin
          // a stop here abandons the open packet; pkt stays as tracked
          if (ctl_stp || (xfr && str.str_lst)) begin
            state_nxt = IDLE;
            evt_nxt   = 1'b1;
          end
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  // status decode of the upcoming state, registered below
  always_comb begin
    ena_nxt = 1'b0;
    arm_nxt = 1'b0;
    run_nxt = 1'b0;
    case (state_nxt)
      ARMED: arm_nxt = 1'b1;
      RUN, DRAIN: begin
        ena_nxt = 1'b1;
        run_nxt = 1'b1;
      end
      default: begin
        ena_nxt = 1'b0;
      end
    endcase
  end

  // registered outputs, counter and packet bit
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      str.ena <= 1'b0;
      sts_arm <= 1'b0;
      sts_run <= 1'b0;
      sts_cnt <= '0;
      evt_end <= 1'b0;
      pkt     <= 1'b0;
    end else begin
      str.ena <= ena_nxt;
      sts_arm <= arm_nxt;
      sts_run <= run_nxt;
      sts_cnt <= cnt_nxt;
      evt_end <= evt_nxt;
      pkt     <= pkt_nxt;
    end
  end

endmodule
